// File: rtl/i2c_pkg.sv
// Shared state encoding and bus-level ACK/NACK values for the I2C slave model.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        IGNORE
    } state_t;

    // Line levels: ACK pulls SDA low, NACK leaves it released
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchronizers plus edge, START and STOP detection on the synced lines.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = SYNC_STAGES'({scl_sync_q, scl_in});
        sda_sync_d = SYNC_STAGES'({sda_sync_q, sda_in});
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Preset to the idle-bus level so leaving reset never looks like a START
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_model.sv
// I2C target with FIFO-style byte interfaces and clock stretching on TX underrun.
module i2c_slave_model
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    inout  wire        scl,
    input  logic [7:0] data_in,
    input  logic       i_txff_empty,
    output logic       o_txff_rd,
    output logic [7:0] data_out,
    input  logic       i_rxff_full,
    output logic       o_rxff_wr,
    output logic       rw,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl),
        .sda_in    (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_out_q, data_out_d;
    logic       byte_done_q, byte_done_d;
    logic       ack_q, ack_d;
    logic       load_pend_q, load_pend_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       sda_out_q, sda_out_d;
    logic       scl_hold_q, scl_hold_d;
    logic       txff_rd_q, txff_rd_d;
    logic       rxff_wr_q, rxff_wr_d;
    logic       tx_enter;

    assign sda       = sda_out_q ? 1'bz : 1'b0;
    assign scl       = scl_hold_q ? 1'b0 : 1'bz;
    assign o_txff_rd = txff_rd_q;
    assign o_rxff_wr = rxff_wr_q;
    assign data_out  = data_out_q;
    assign rw        = rw_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        byte_done_d = byte_done_q;
        ack_d       = ack_q;
        load_pend_d = load_pend_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        sda_out_d   = sda_out_q;
        scl_hold_d  = scl_hold_q;
        txff_rd_d   = 1'b0;
        rxff_wr_d   = 1'b0;
        tx_enter    = 1'b0;

        // Bus conditions override any data-bit edge seen in the same cycle
        if (start_det || stop_det) begin
            state_d     = start_det ? ADDR : IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            load_pend_d = 1'b0;
            sda_out_d   = NACK;
            scl_hold_d  = 1'b0;
            if (stop_det) busy_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, RX_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                            if (state_q == RX_DATA) begin
                                data_out_d = {shift_q[6:0], sda_s};
                                ack_d      = ~i_rxff_full;
                                rxff_wr_d  = ~i_rxff_full;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (state_q == RX_DATA) begin
                            state_d   = RX_ACK;
                            sda_out_d = ack_q ? ACK : NACK;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d   = ADDR_ACK;
                            rw_d      = shift_q[0];
                            busy_d    = 1'b1;
                            sda_out_d = ACK;
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_out_d = NACK;
                        state_d   = rw_q ? TX_DATA : RX_DATA;
                        tx_enter  = rw_q;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_out_d = NACK;
                        state_d   = ack_q ? RX_DATA : IGNORE;
                        if (!ack_q) busy_d = 1'b0;
                    end
                end
                TX_DATA: begin
                    if (!load_pend_q) begin
                        if (scl_rise) begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done_q) begin
                                byte_done_d = 1'b0;
                                state_d     = TX_ACK;
                                sda_out_d   = NACK;
                            end else begin
                                shift_d   = {shift_q[6:0], 1'b0};
                                sda_out_d = shift_q[6];
                            end
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        ack_d = (sda_s == ACK);
                    end else if (scl_fall) begin
                        state_d  = ack_q ? TX_DATA : IGNORE;
                        tx_enter = ack_q;
                        if (!ack_q) busy_d = 1'b0;
                    end
                end
                default: ;
            endcase

            // Load the next TX byte now, or keep SCL stretched until one is available
            if (tx_enter || (state_q == TX_DATA && load_pend_q)) begin
                if (!i_txff_empty) begin
                    shift_d     = data_in;
                    sda_out_d   = data_in[7];
                    txff_rd_d   = 1'b1;
                    load_pend_d = 1'b0;
                    scl_hold_d  = 1'b0;
                end else begin
                    load_pend_d = 1'b1;
                    scl_hold_d  = 1'b1;
                    sda_out_d   = NACK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
            load_pend_q <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            sda_out_q   <= NACK;
            scl_hold_q  <= 1'b0;
            txff_rd_q   <= 1'b0;
            rxff_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            byte_done_q <= byte_done_d;
            ack_q       <= ack_d;
            load_pend_q <= load_pend_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            sda_out_q   <= sda_out_d;
            scl_hold_q  <= scl_hold_d;
            txff_rd_q   <= txff_rd_d;
            rxff_wr_q   <= rxff_wr_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_model.sv
// Directed bench: bit-banged I2C master, TX/RX FIFO models and byte scoreboards.
module tb_i2c_slave_model;
    import i2c_pkg::*;

    localparam int Q     = 20;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_sda, m_scl;
    logic       i_rxff_full;
    logic       o_txff_rd, o_rxff_wr, rw, busy;
    logic [7:0] data_in, data_out;
    logic       i_txff_empty;
    wire        sda, scl;

    pullup (sda);
    pullup (scl);
    assign sda = m_sda ? 1'bz : 1'b0;
    assign scl = m_scl ? 1'bz : 1'b0;

    logic [7:0] tx_mem [8];
    int         tx_wr = 0, tx_rd = 0, tx_viol = 0;
    logic [7:0] rx_log [16];
    int         rx_cnt = 0, rx_chk = 0, rx_viol = 0;
    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];
    int         vectors = 0, miscompares = 0;
    int         fill_after = 0;
    logic [7:0] fill_byte;

    assign i_txff_empty = (tx_wr == tx_rd);
    assign data_in      = tx_mem[tx_rd[2:0]];

    i2c_slave_model #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sda          (sda),
        .scl          (scl),
        .data_in      (data_in),
        .i_txff_empty (i_txff_empty),
        .o_txff_rd    (o_txff_rd),
        .data_out     (data_out),
        .i_rxff_full  (i_rxff_full),
        .o_rxff_wr    (o_rxff_wr),
        .rw           (rw),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rxff_wr) begin
            rx_log[rx_cnt[3:0]] <= data_out;
            rx_cnt <= rx_cnt + 1;
            if (i_rxff_full) rx_viol <= rx_viol + 1;
        end
        if (o_txff_rd) begin
            if (tx_wr == tx_rd) tx_viol <= tx_viol + 1;
            tx_rd <= tx_rd + 1;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_mem[tx_wr[2:0]] = b;
        tx_wr++;
        exp_tx.push_back(b);
    endtask

    // Release SCL and wait for the line to rise, honouring target clock stretching
    task automatic scl_high(output int st);
        m_scl = 1'b1;
        st = 0;
        while (scl !== 1'b1 && st < LIMIT) begin
            @(negedge clk);
            st++;
            if (fill_after != 0 && st == fill_after) begin
                tx_push(fill_byte);
                fill_after = 0;
            end
        end
        if (st >= LIMIT) chk("scl_release_timeout", 32'(scl), 32'd1);
    endtask

    task automatic send_bit(input logic b, output logic rd, output int st);
        m_sda = b;
        wait_q();
        scl_high(st);
        wait_q();
        rd = sda;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic start_cond();
        int st;
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            wait_q();
            scl_high(st);
            wait_q();
        end
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic stop_cond();
        int st;
        m_sda = 1'b0;
        wait_q();
        scl_high(st);
        wait_q();
        m_sda = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        int   st;
        for (int i = 7; i >= 0; i--) send_bit(b[i], r, st);
        send_bit(1'b1, ack, st);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output int st0);
        logic r;
        int   st;
        d = 8'h00;
        st0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, r, st);
            if (i == 0) st0 = st;
            d = {d[6:0], r};
        end
        send_bit(mack, r, st);
    endtask

    task automatic check_tx(input string tag, input logic [7:0] d);
        if (exp_tx.size() > 0) chk(tag, 32'(d), 32'(exp_tx.pop_front()));
        else chk({tag, "_unexpected"}, 32'(exp_tx.size()), 32'd1);
    endtask

    task automatic drain_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_cnt - rx_chk), 32'(exp_rx.size()));
        while (exp_rx.size() > 0) begin
            if (rx_chk < rx_cnt) chk(tag, 32'(rx_log[rx_chk[3:0]]), 32'(exp_rx[0]));
            void'(exp_rx.pop_front());
            rx_chk++;
        end
        rx_chk = rx_cnt;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         st, tx0;

        rst = 1'b1;
        m_sda = 1'b1;
        m_scl = 1'b1;
        i_rxff_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_rxff_wr", 32'(o_rxff_wr), 32'd0);
        chk("rst_txff_rd", 32'(o_txff_rd), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_state", 32'(dut.state_q), 32'(IDLE));

        // Plain write of two bytes
        start_cond();
        write_byte(8'hA0, ack);
        chk("wr_addr_ack", 32'(ack), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_rw", 32'(rw), 32'd0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        chk("wr_b1_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h81);
        write_byte(8'h81, ack);
        chk("wr_b2_ack", 32'(ack), 32'd0);
        chk("wr_busy_pre_stop", 32'(busy), 32'd1);
        stop_cond();
        chk("wr_busy_post_stop", 32'(busy), 32'd0);
        chk("wr_state_stop", 32'(dut.state_q), 32'(IDLE));
        drain_rx("wr_data");

        // Foreign address is ignored
        tx0 = tx_rd;
        start_cond();
        write_byte(8'hA2, ack);
        chk("miss_nack", 32'(ack), 32'd1);
        chk("miss_state", 32'(dut.state_q), 32'(IGNORE));
        chk("miss_busy", 32'(busy), 32'd0);
        stop_cond();
        drain_rx("miss_rx");
        chk("miss_tx_pops", 32'(tx_rd - tx0), 32'd0);

        // Read two bytes, ACK then NACK
        tx_push(8'h5A);
        tx_push(8'hC3);
        tx0 = tx_rd;
        start_cond();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'd0);
        chk("rd_rw", 32'(rw), 32'd1);
        read_byte(1'b0, d, st);
        check_tx("rd_b0", d);
        read_byte(1'b1, d, st);
        check_tx("rd_b1", d);
        chk("rd_state_nack", 32'(dut.state_q), 32'(IGNORE));
        chk("rd_tx_pops", 32'(tx_rd - tx0), 32'd2);
        stop_cond();

        // Read with an empty TX FIFO: target stretches until a byte arrives
        tx0 = tx_rd;
        start_cond();
        write_byte(8'hA1, ack);
        chk("st_addr_ack", 32'(ack), 32'd0);
        fill_byte = 8'h96;
        fill_after = 200;
        read_byte(1'b1, d, st);
        chk("st_stretch_ge200", 32'(st >= 200), 32'd1);
        check_tx("st_data", d);
        chk("st_tx_pops", 32'(tx_rd - tx0), 32'd1);
        stop_cond();

        // Reset while the target is stretching SCL
        start_cond();
        write_byte(8'hA1, ack);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_scl_held", 32'(scl), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_scl", 32'(scl), 32'd1);
        chk("mid_rst_sda", 32'(sda), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_rst_busy", 32'(busy), 32'd0);

        // RX FIFO full on the second data byte
        start_cond();
        write_byte(8'hA0, ack);
        chk("full_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h42);
        write_byte(8'h42, ack);
        chk("full_b0_ack", 32'(ack), 32'd0);
        i_rxff_full = 1'b1;
        write_byte(8'h99, ack);
        chk("full_b1_nack", 32'(ack), 32'd1);
        chk("full_state", 32'(dut.state_q), 32'(IGNORE));
        drain_rx("full_rx");
        i_rxff_full = 1'b0;
        stop_cond();

        // Write one byte, repeated START, then read
        tx_push(8'h77);
        start_cond();
        write_byte(8'hA0, ack);
        chk("rs_waddr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'hE5);
        write_byte(8'hE5, ack);
        chk("rs_wdata_ack", 32'(ack), 32'd0);
        chk("rs_rw_before", 32'(rw), 32'd0);
        start_cond();
        chk("rs_busy_rstart", 32'(busy), 32'd1);
        write_byte(8'hA1, ack);
        chk("rs_raddr_ack", 32'(ack), 32'd0);
        chk("rs_rw_after", 32'(rw), 32'd1);
        chk("rs_busy_read", 32'(busy), 32'd1);
        read_byte(1'b1, d, st);
        check_tx("rs_rdata", d);
        stop_cond();
        chk("rs_busy_end", 32'(busy), 32'd0);
        drain_rx("rs_rx");

        chk("txrd_while_empty", 32'(tx_viol), 32'd0);
        chk("rxwr_while_full", 32'(rx_viol), 32'd0);
        chk("tx_fifo_drained", 32'(tx_wr - tx_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave_model.md
I2C_SLAVE_MODEL -- requirements
Module: i2c_slave_model

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit target address matched after START.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of flops in the SCL/SDA input synchronizers.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock in the block.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sda, inout, 1: open-drain data line; the block drives only 0 or Z.
REQ-006 SHALL have port scl, inout, 1: open-drain clock line; the block drives only 0 (stretch) or Z.
REQ-007 SHALL have port data_in, input, 8: byte supplied from the TX FIFO for master reads.
REQ-008 SHALL have port i_txff_empty, input, 1: TX FIFO empty flag.
REQ-009 SHALL have port o_txff_rd, output, 1: one-clk pop strobe to the TX FIFO.
REQ-010 SHALL have port data_out, output, 8: last byte received from the master.
REQ-011 SHALL have port i_rxff_full, input, 1: RX FIFO full flag.
REQ-012 SHALL have port o_rxff_wr, output, 1: one-clk push strobe to the RX FIFO, valid with data_out.
REQ-013 SHALL have port rw, output, 1: R/W bit of the current transfer (1 = master read).
REQ-014 SHALL have port busy, output, 1: high from an addressed START until STOP or NACK return to IDLE.

Function
REQ-015 SHALL synchronize scl and sda through SYNC_STAGES flops, then register the results once more for edge detection.
REQ-016 SHALL detect START as a falling edge of synced SDA while synced SCL is high, and STOP as a rising edge of SDA while SCL is high.
REQ-017 SHALL sample SDA only on a synced SCL rising edge and change its SDA drive only on a synced SCL falling edge.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK and IGNORE.
REQ-019 SHALL move from any state to ADDR on START (repeated START included), and to IDLE on STOP.
REQ-020 SHALL in ADDR shift in 8 bits MSB first; on the 8th falling edge, it SHALL go to ADDR_ACK if bits[7:1]==SLAVE_ADDR, otherwise to IGNORE.
REQ-021 SHALL in ADDR_ACK drive SDA low for one SCL period and latch rw; it SHALL then go to TX_DATA if rw=1, else RX_DATA.
REQ-022 SHALL in RX_DATA shift 8 bits; on the 8th rising edge, it SHALL update data_out and pulse o_rxff_wr for 1 clk if i_rxff_full=0.
REQ-023 SHALL in RX_ACK drive ACK (0) if the byte was pushed, or NACK (Z) if i_rxff_full was 1; after NACK it SHALL go to IGNORE, else back to RX_DATA.
REQ-024 SHALL on entry to TX_DATA (the falling edge ending ADDR_ACK or TX_ACK) load data_in into the shift register and pulse o_txff_rd for 1 clk.
REQ-025 SHALL, if i_txff_empty=1 at that falling edge, hold SCL low (stretch) until i_txff_empty=0, then load, pop and release SCL.
REQ-026 SHALL in TX_DATA drive bit 7..0 on successive falling edges, with 0 driven as low and 1 as Z.
REQ-027 SHALL in TX_ACK release SDA and sample the master's bit: 0 returns to TX_DATA, 1 (NACK) goes to IGNORE.
REQ-028 SHALL in IGNORE and IDLE release both lines and wait for START or STOP.
REQ-029 SHALL use a 3-bit bit counter that wraps 7 to 0 per byte; a byte aborted by START/STOP SHALL produce no o_rxff_wr.
REQ-030 SHALL never assert o_txff_rd while i_txff_empty=1 or o_rxff_wr while i_rxff_full=1.
REQ-031 SHALL let STOP/START take priority over a coincident data-bit edge.

Reset
REQ-032 SHALL on rst=1 at a clk edge go to IDLE, release sda/scl (Z), and clear data_out=8'h00, o_txff_rd=0, o_rxff_wr=0, rw=0, busy=0, the counter and the shift register.
REQ-033 SHALL preset the synchronizer flops to 1 (idle bus) on reset, so no false START appears after reset.
REQ-034 SHALL, when reset is asserted mid-transfer, release the bus within 1 clk.

Structure
REQ-035 SHALL take its state encoding and the ACK/NACK constants from a shared package, i2c_pkg.
REQ-036 SHALL place SCL/SDA sync and edge/START/STOP detection in one sub-module, i2c_bus_monitor.

Verification
REQ-037 Master writes 0xA0, 0x3C, 0x81, STOP -> ACK on all three bytes, two o_rxff_wr pulses with data_out 0x3C then 0x81, busy falls at STOP.
REQ-038 Master sends address 0xA2 -> no ACK (SDA Z at the 9th clock), state IGNORE, no FIFO strobes.
REQ-039 Master reads 0xA1 with TX FIFO holding 0x5A, 0xC3; master ACKs then NACKs -> bits 0x5A then 0xC3 on SDA, two o_txff_rd pulses, IGNORE after NACK.
REQ-040 Read with i_txff_empty=1 for 200 clks after the address ACK -> SCL held low 200+ clks, released after the load, first bit correct.
REQ-041 Write with i_rxff_full=1 on the 2nd data byte -> NACK on that byte, no o_rxff_wr, IGNORE.
REQ-042 Repeated START after a write of 1 byte, then a read -> rw goes 0 to 1, busy stays 1, data flows correctly.
